// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: mode, opcode, ALU command,
// condition codes and status-register bit positions.
package id_stage_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  localparam logic [3:0] REG_PC = 4'hF;

endpackage

// File: rtl/register_file.sv
// Architectural register file R0-R14: two async read ports, one write port
// on the falling edge so a same-cycle writeback reaches the decode read.
module register_file
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rd_addr1_i,
  input  logic [3:0]  rd_addr2_i,
  output logic [31:0] rd_data1_o,
  output logic [31:0] rd_data2_o,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_addr_i,
  input  logic [31:0] wr_data_i
);

  logic [31:0] regs_q [15];

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i && (wr_addr_i != REG_PC)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Index 15 has no storage behind it and always reads as zero.
  assign rd_data1_o = (rd_addr1_i == REG_PC) ? 32'd0 : regs_q[rd_addr1_i];
  assign rd_data2_o = (rd_addr2_i == REG_PC) ? 32'd0 : regs_q[rd_addr2_i];

endmodule

// File: rtl/id_stage.sv
// ARM instruction-decode stage: IF/ID register with freeze/flush, operand
// read, condition-gated control decode and hazard source export.
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instruction,
  input  logic [3:0]  sr,
  input  logic        wb_en,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic [31:0] pc,
  output logic [31:0] val_rn,
  output logic [31:0] val_rm,
  output logic [3:0]  exe_cmd,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        wb_en_out,
  output logic        b,
  output logic        s,
  output logic        imm,
  output logic [11:0] shift_operand,
  output logic [23:0] signed_imm24,
  output logic [3:0]  dest,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        two_src,
  output logic        valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!freeze) begin
      pc_d    = if_pc;
      instr_d = if_instruction;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  logic [3:0] cond;
  logic [1:0] mode;
  logic       i_bit;
  logic [3:0] opcode;
  logic       s_bit;
  logic [3:0] rn, rd, rm;
  logic       is_store;

  assign cond     = instr_q[31:28];
  assign mode     = instr_q[27:26];
  assign i_bit    = instr_q[25];
  assign opcode   = instr_q[24:21];
  assign s_bit    = instr_q[20];
  assign rn       = instr_q[19:16];
  assign rd       = instr_q[15:12];
  assign rm       = instr_q[3:0];
  assign is_store = (mode == MODE_MEM) && !s_bit;

  logic cond_ok;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_EQ: cond_ok = sr[SR_Z];
      COND_NE: cond_ok = !sr[SR_Z];
      COND_CS: cond_ok = sr[SR_C];
      COND_CC: cond_ok = !sr[SR_C];
      COND_MI: cond_ok = sr[SR_N];
      COND_PL: cond_ok = !sr[SR_N];
      COND_VS: cond_ok = sr[SR_V];
      COND_VC: cond_ok = !sr[SR_V];
      COND_HI: cond_ok = sr[SR_C] && !sr[SR_Z];
      COND_LS: cond_ok = !sr[SR_C] || sr[SR_Z];
      COND_GE: cond_ok = (sr[SR_N] == sr[SR_V]);
      COND_LT: cond_ok = (sr[SR_N] != sr[SR_V]);
      COND_GT: cond_ok = !sr[SR_Z] && (sr[SR_N] == sr[SR_V]);
      COND_LE: cond_ok = sr[SR_Z] || (sr[SR_N] != sr[SR_V]);
      COND_AL: cond_ok = 1'b1;
      COND_NV: cond_ok = 1'b0;
      default: cond_ok = 1'b0;
    endcase
  end

  logic [3:0] cmd_raw;
  logic       wb_raw, mr_raw, mw_raw, b_raw, s_raw;

  always_comb begin
    cmd_raw = EXE_NOP;
    wb_raw  = 1'b0;
    mr_raw  = 1'b0;
    mw_raw  = 1'b0;
    b_raw   = 1'b0;
    s_raw   = 1'b0;
    case (mode)
      MODE_DP: begin
        s_raw = s_bit;
        case (opcode)
          OP_MOV: begin cmd_raw = EXE_MOV; wb_raw = 1'b1; end
          OP_MVN: begin cmd_raw = EXE_MVN; wb_raw = 1'b1; end
          OP_ADD: begin cmd_raw = EXE_ADD; wb_raw = 1'b1; end
          OP_ADC: begin cmd_raw = EXE_ADC; wb_raw = 1'b1; end
          OP_SUB: begin cmd_raw = EXE_SUB; wb_raw = 1'b1; end
          OP_SBC: begin cmd_raw = EXE_SBC; wb_raw = 1'b1; end
          OP_AND: begin cmd_raw = EXE_AND; wb_raw = 1'b1; end
          OP_ORR: begin cmd_raw = EXE_ORR; wb_raw = 1'b1; end
          OP_EOR: begin cmd_raw = EXE_EOR; wb_raw = 1'b1; end
          OP_CMP: cmd_raw = EXE_SUB;
          OP_TST: cmd_raw = EXE_AND;
          default: s_raw = 1'b0;
        endcase
      end
      MODE_MEM: begin
        cmd_raw = EXE_ADD;
        if (s_bit) begin
          mr_raw = 1'b1;
          wb_raw = 1'b1;
        end else begin
          mw_raw = 1'b1;
        end
      end
      MODE_BR: b_raw = 1'b1;
      default: ;
    endcase
  end

  logic bubble;
  assign bubble = freeze || !valid_q || !cond_ok;

  assign exe_cmd   = bubble ? EXE_NOP : cmd_raw;
  assign mem_r_en  = !bubble && mr_raw;
  assign mem_w_en  = !bubble && mw_raw;
  assign wb_en_out = !bubble && wb_raw;
  assign b         = !bubble && b_raw;
  assign s         = !bubble && s_raw;

  // Store selection for src2 uses the raw decode so hazard sources are not
  // disturbed by the bubble; two_src is qualified by valid so reset/flush read 0.
  assign src2          = is_store ? rd : rm;
  assign src1          = rn;
  assign dest          = rd;
  assign imm           = i_bit;
  assign two_src       = valid_q && (!i_bit || is_store);
  assign shift_operand = instr_q[11:0];
  assign signed_imm24  = instr_q[23:0];
  assign pc            = pc_q;
  assign valid         = valid_q;

  register_file u_register_file (
    .clk        (clk),
    .rst        (rst),
    .rd_addr1_i (rn),
    .rd_addr2_i (src2),
    .rd_data1_o (val_rn),
    .rd_data2_o (val_rm),
    .wr_en_i    (wb_en),
    .wr_addr_i  (wb_dest),
    .wr_data_i  (wb_value)
  );

endmodule
